sram_req_arbiter: RTL and testbench

SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

---
 rtl/sram_req_arbiter.sv | 139 +++++++++++++
 tb/tb_sram_req_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Two-master (fetch + load/store) arbiter onto one sram-like port.
// Responses are steered back through an in-order ID FIFO tracking accepted transactions.
module sram_req_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       inst_req,
    input  logic [31:0]                inst_addr,
    output logic                       inst_addr_ok,
    output logic                       inst_data_ok,
    output logic [31:0]                inst_rdata,

    input  logic                       data_req,
    input  logic                       data_wr,
    input  logic [1:0]                 data_size,
    input  logic [3:0]                 data_wstrb,
    input  logic [31:0]                data_addr,
    input  logic [31:0]                data_wdata,
    output logic                       data_addr_ok,
    output logic                       data_data_ok,
    output logic [31:0]                data_rdata,

    output logic                       req,
    output logic                       wr,
    output logic [1:0]                 size,
    output logic [3:0]                 wstrb,
    output logic [31:0]                addr,
    output logic [31:0]                wdata,
    input  logic                       addr_ok,
    input  logic                       data_ok,
    input  logic [31:0]                rdata,

    output logic [$clog2(DEPTH):0]     outstanding
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } gnt_t;

    // Handshake: a request moves on the shared port in the cycle where
    // req & addr_ok are both high; a response completes in the cycle data_ok
    // is high. No ready-style backpressure exists on the response side.

    logic             lock;
    gnt_t             lock_id;
    gnt_t             grant;
    logic [DEPTH-1:0] id_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic full;
    logic push;
    logic pop;
    gnt_t head;

    assign full = (count == CW'(DEPTH));
    assign head = gnt_t'(id_q[rd_ptr]);
    assign push = req & addr_ok;
    assign pop  = data_ok & (count != '0);

    // A request that was presented but not taken stays pinned to its owner.
    always_comb begin
        grant = GNT_INST;
        if (lock) begin
            grant = lock_id;
        end else if (data_req) begin
            grant = GNT_DATA;
        end
    end

    always_comb begin
        req   = (inst_req | data_req) & ~full;
        wr    = 1'b0;
        size  = 2'd2;
        wstrb = 4'b0000;
        addr  = inst_addr;
        wdata = 32'h0;
        if (grant == GNT_DATA) begin
            wr    = data_wr;
            size  = data_size;
            wstrb = data_wstrb;
            addr  = data_addr;
            wdata = data_wdata;
        end
    end

    always_comb begin
        inst_addr_ok = push & (grant == GNT_INST);
        data_addr_ok = push & (grant == GNT_DATA);
        inst_data_ok = pop & (head == GNT_INST);
        data_data_ok = pop & (head == GNT_DATA);
        inst_rdata   = rdata;
        data_rdata   = rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock    <= 1'b0;
            lock_id <= GNT_INST;
        end else if (req & addr_ok) begin
            lock    <= 1'b0;
        end else if (req) begin
            lock    <= 1'b1;
            lock_id <= grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_q   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                id_q[wr_ptr] <= grant;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign outstanding = count;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: arbitration, lock, ordering, full and reset cases.
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        req, wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic [2:0]  outstanding;

    int checks = 0;
    int errors = 0;

    sram_req_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_addr = 32'h1000;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = 32'h2000; data_wdata = 32'h0;
        addr_ok = 0; data_ok = 0; rdata = 32'h0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_req", req, 1'b0);
        check("rst_iaok", inst_addr_ok, 1'b0);
        check("rst_daok", data_addr_ok, 1'b0);
        check("rst_idok", inst_data_ok, 1'b0);
        check("rst_ddok", data_data_ok, 1'b0);
        check("rst_out", outstanding, 3'd0);

        // Simultaneous requests: data first, inst next cycle
        inst_req = 1; data_req = 1; addr_ok = 1;
        #1;
        check("both_req", req, 1'b1);
        check("both_daok", data_addr_ok, 1'b1);
        check("both_iaok", inst_addr_ok, 1'b0);
        check("both_addr", addr, 32'h2000);
        tick();
        check("both_out1", outstanding, 3'd1);
        data_req = 0;
        #1;
        check("inst2_iaok", inst_addr_ok, 1'b1);
        check("inst2_addr", addr, 32'h1000);
        check("inst2_wr", wr, 1'b0);
        check("inst2_size", size, 2'd2);
        tick();
        check("both_out2", outstanding, 3'd2);
        inst_req = 0; addr_ok = 0;
        data_ok = 1; rdata = 32'hA;
        #1;
        check("drain1_ddok", data_data_ok, 1'b1);
        check("drain1_idok", inst_data_ok, 1'b0);
        check("drain1_rdata", data_rdata, 32'hA);
        tick();
        rdata = 32'hB;
        #1;
        check("drain2_idok", inst_data_ok, 1'b1);
        check("drain2_rdata", inst_rdata, 32'hB);
        tick();
        data_ok = 0;
        check("drain_out0", outstanding, 3'd0);

        // Lock holds the fetch request while data_req arrives
        inst_req = 1; inst_addr = 32'h1100; data_addr = 32'h3000;
        #1;
        check("lk1_addr", addr, 32'h1100);
        tick();
        data_req = 1;
        #1;
        check("lk2_addr", addr, 32'h1100);
        check("lk2_daok", data_addr_ok, 1'b0);
        tick();
        #1;
        check("lk3_addr", addr, 32'h1100);
        tick();
        addr_ok = 1;
        #1;
        check("lk4_iaok", inst_addr_ok, 1'b1);
        check("lk4_daok", data_addr_ok, 1'b0);
        check("lk4_addr", addr, 32'h1100);
        tick();
        #1;
        check("lk5_daok", data_addr_ok, 1'b1);
        check("lk5_addr", addr, 32'h3000);
        tick();
        check("lk_out2", outstanding, 3'd2);
        inst_req = 0; data_req = 0; addr_ok = 0;
        data_ok = 1; rdata = 32'h5;
        #1;
        check("lkd1_idok", inst_data_ok, 1'b1);
        tick();
        rdata = 32'h6;
        #1;
        check("lkd2_ddok", data_data_ok, 1'b1);
        tick();
        data_ok = 0;

        // Fill to DEPTH, then one pop re-enables req
        data_req = 1; addr_ok = 1; data_addr = 32'h4000;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fill_daok", data_addr_ok, 1'b1);
            tick();
        end
        check("full_out", outstanding, 3'd4);
        #1;
        check("full_req", req, 1'b0);
        check("full_daok", data_addr_ok, 1'b0);
        data_ok = 1; rdata = 32'h77;
        #1;
        check("full_pop_ddok", data_data_ok, 1'b1);
        check("full_pop_req", req, 1'b0);
        tick();
        data_ok = 0;
        #1;
        check("refill_out", outstanding, 3'd3);
        check("refill_req", req, 1'b1);
        tick();
        check("refill_out4", outstanding, 3'd4);
        data_req = 0; addr_ok = 0; data_ok = 1;
        for (int i = 0; i < 4; i++) tick();
        data_ok = 0;
        check("empty_out", outstanding, 3'd0);

        // Order: inst, store, inst -> responses in same order
        inst_req = 1; addr_ok = 1;
        tick();
        inst_req = 0; data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
        data_addr = 32'h5000; data_size = 2'd2;
        #1;
        check("st_wr", wr, 1'b1);
        check("st_wstrb", wstrb, 4'hF);
        check("st_wdata", wdata, 32'hDEAD_BEEF);
        tick();
        data_req = 0; data_wr = 0; data_wstrb = 4'h0; inst_req = 1;
        tick();
        inst_req = 0; addr_ok = 0;
        check("ord_out3", outstanding, 3'd3);
        data_ok = 1; rdata = 32'h11;
        #1;
        check("ord1_idok", inst_data_ok, 1'b1);
        check("ord1_ddok", data_data_ok, 1'b0);
        check("ord1_rdata", inst_rdata, 32'h11);
        tick();
        rdata = 32'h22;
        #1;
        check("ord2_ddok", data_data_ok, 1'b1);
        check("ord2_idok", inst_data_ok, 1'b0);
        check("ord2_rdata", data_rdata, 32'h22);
        tick();
        rdata = 32'h33;
        #1;
        check("ord3_idok", inst_data_ok, 1'b1);
        check("ord3_rdata", inst_rdata, 32'h33);
        tick();
        data_ok = 0;
        check("ord_out0", outstanding, 3'd0);

        // Simultaneous push and pop, then spurious data_ok
        inst_req = 1; addr_ok = 1;
        tick(); tick();
        check("sim_out2", outstanding, 3'd2);
        inst_req = 0; data_req = 1; data_ok = 1; rdata = 32'h44;
        #1;
        check("sim_daok", data_addr_ok, 1'b1);
        check("sim_idok", inst_data_ok, 1'b1);
        tick();
        check("sim_out_hold", outstanding, 3'd2);
        data_req = 0; addr_ok = 0;
        #1;
        check("sim_head_idok", inst_data_ok, 1'b1);
        tick();
        #1;
        check("sim_tail_ddok", data_data_ok, 1'b1);
        tick();
        check("sim_out0", outstanding, 3'd0);
        #1;
        check("spur_idok", inst_data_ok, 1'b0);
        check("spur_ddok", data_data_ok, 1'b0);
        tick();
        data_ok = 0;
        check("spur_out", outstanding, 3'd0);

        // Reset with 3 outstanding and lock held
        inst_req = 1; addr_ok = 1; inst_addr = 32'h1200; data_addr = 32'h6000;
        tick(); tick(); tick();
        addr_ok = 0;
        tick();
        check("prerst_out", outstanding, 3'd3);
        data_req = 1;
        #1;
        check("prerst_addr", addr, 32'h1200);
        reset = 1;
        tick();
        reset = 0;
        #1;
        check("postrst_out", outstanding, 3'd0);
        check("postrst_addr", addr, 32'h6000);
        check("postrst_req", req, 1'b1);
        inst_req = 0; data_req = 0; data_ok = 1;
        #1;
        check("postrst_idok", inst_data_ok, 1'b0);
        check("postrst_ddok", data_data_ok, 1'b0);
        tick();
        data_ok = 0;
        check("postrst_out2", outstanding, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
